la_capture_streamer: RTL and testbench

Trigger-armed capture buffer for the logic analyzer. It samples an 8-bit probe bus into on-chip memory after a programmable trigger match. It then streams the captured block out as a framed byte sequence to the UART transmitter, and sits directly upstream of `uart_tx`. Its `o_tx_byte` / `o_tx_valid` drive the transmitter's `i_data_byte` / `i_data_valid`, and it paces itself on the transmitter's `o_active`.

---
 rtl/la_capture_streamer.sv | 158 +++++++++++++++
 tb/tb_la_capture_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_streamer.sv
// Trigger-armed 8-bit probe capture; streams SYNC, DEPTH-1, samples, XOR checksum to uart_tx.
// Outputs registered (strobe 1 cycle after TX_LOAD); waits in TX_LOAD while i_tx_active is high.
module la_capture_streamer #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_probe,
  input  logic       i_sample_en,
  input  logic       i_arm,
  input  logic [7:0] i_trig_mask,
  input  logic [7:0] i_trig_value,
  input  logic       i_tx_active,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_valid,
  output logic       o_armed,
  output logic       o_busy
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] addr_t;
  localparam addr_t      LAST_ADDR = addr_t'(DEPTH-1);
  localparam logic [8:0] LAST_IDX  = 9'(DEPTH+2);
  localparam logic [7:0] LEN_BYTE  = 8'(DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_TX_LOAD, S_TX_ACK, S_TX_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_mem [DEPTH];
  addr_t      r_addr;
  logic [7:0] r_csum;
  logic [8:0] r_idx;
  logic [7:0] r_tx_byte;
  logic       r_tx_valid;
  logic       r_armed;
  logic       r_busy;

  logic       w_match;
  logic       w_we;
  logic       w_clr;
  logic       w_load;
  logic       w_idx_inc;
  addr_t      w_rd_addr;
  logic [7:0] w_frame_byte;

  assign w_match = ((i_probe & i_trig_mask) == (i_trig_value & i_trig_mask));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_clr     = 1'b0;
    w_load    = 1'b0;
    w_idx_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_clr  = 1'b1;
          w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (i_sample_en && w_match) begin
          w_we   = 1'b1;
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (i_sample_en) begin
          w_we = 1'b1;
          if (r_addr == LAST_ADDR) w_next = S_TX_LOAD;
        end
      end
      S_TX_LOAD: begin
        if (!i_tx_active) begin
          w_load = 1'b1;
          w_next = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (i_tx_active) w_next = S_TX_DONE;
      end
      S_TX_DONE: begin
        if (!i_tx_active) begin
          if (r_idx == LAST_IDX) begin
            w_next = S_IDLE;
          end else begin
            w_idx_inc = 1'b1;
            w_next    = S_TX_LOAD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Samples sit at frame indices 2..DEPTH+1, so the read address is index-2.
  assign w_rd_addr = addr_t'(r_idx - 9'd2);

  always_comb begin
    w_frame_byte = r_mem[w_rd_addr];
    if (r_idx == 9'd0)          w_frame_byte = SYNC_BYTE;
    else if (r_idx == 9'd1)     w_frame_byte = LEN_BYTE;
    else if (r_idx == LAST_IDX) w_frame_byte = r_csum;
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[r_addr] <= i_probe;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_csum <= '0;
      r_idx  <= '0;
    end else begin
      if (w_clr) begin
        r_addr <= '0;
        r_csum <= '0;
        r_idx  <= '0;
      end
      if (w_we) begin
        r_addr <= r_addr + addr_t'(1);
        r_csum <= r_csum ^ i_probe;
        if (w_next == S_TX_LOAD) r_idx <= '0;
      end
      if (w_idx_inc) r_idx <= r_idx + 9'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_valid <= w_load;
      if (w_load) r_tx_byte <= w_frame_byte;
      r_armed    <= (w_next == S_ARMED);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  assign o_tx_byte  = r_tx_byte;
  assign o_tx_valid = r_tx_valid;
  assign o_armed    = r_armed;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_la_capture_streamer.sv
// Bench for la_capture_streamer: capture vectors with scoreboarded frame bytes and a uart_tx model.
module tb_la_capture_streamer;
  localparam int         DL   = 2;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         HOLD = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_probe, i_trig_mask, i_trig_value;
  logic       i_sample_en, i_arm, i_tx_active;
  logic [7:0] o_tx_byte;
  logic       o_tx_valid, o_armed, o_busy;

  logic mdl_active, force_busy;
  int   mdl_dly, mdl_hold;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic prev_vld = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  assign i_tx_active = mdl_active | force_busy;

  la_capture_streamer #(.DEPTH_LOG2(DL), .SYNC_BYTE(SYNC)) dut (
    .i_clk(clk), .i_rst(rst), .i_probe(i_probe), .i_sample_en(i_sample_en),
    .i_arm(i_arm), .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value),
    .i_tx_active(i_tx_active), .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid),
    .o_armed(o_armed), .o_busy(o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // uart_tx stand-in: busy from 2 cycles after the load strobe, for HOLD cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_active <= 1'b0;
      mdl_dly    <= 0;
      mdl_hold   <= 0;
    end else begin
      if (mdl_dly == 1) begin
        mdl_dly    <= 0;
        mdl_active <= 1'b1;
        mdl_hold   <= HOLD;
      end else if (mdl_active) begin
        if (mdl_hold == 1) mdl_active <= 1'b0;
        mdl_hold <= mdl_hold - 1;
      end
      if (o_tx_valid) mdl_dly <= 1;
    end
  end

  always @(negedge clk) begin
    if (o_tx_valid) begin
      pulses++;
      chk("pulse_width", 32'(prev_vld), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h required=none", o_tx_byte);
      end else begin
        chk("frame_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
      end
    end
    prev_vld = o_tx_valid;
  end

  typedef struct packed {
    logic [7:0]      mask;
    logic [7:0]      value;
    logic [0:5][7:0] probe;
    int              n;
    int              trig;
    logic [0:3][7:0] exp_s;
    logic [7:0]      exp_csum;
  } vec_t;

  vec_t vecs[4];

  task automatic zero_check(input string name);
    chk(name, {21'd0, o_tx_byte, o_tx_valid, o_armed, o_busy}, 0);
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1 zero_check(name);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    for (int c = 0; c < 5000 && pulses < target; c++) @(negedge clk);
    chk("pulse_wait_timeout", 32'(pulses >= target), 1);
  endtask

  task automatic capture_vec(input vec_t v, input bit noise_arm, input bit bp);
    exp_q.push_back(SYNC);
    exp_q.push_back(8'((1 << DL) - 1));
    for (int i = 0; i < 4; i++) exp_q.push_back(v.exp_s[i]);
    exp_q.push_back(v.exp_csum);
    @(negedge clk);
    i_trig_mask = v.mask;
    i_trig_value = v.value;
    i_arm = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
    chk("armed_after_arm", 32'(o_armed), 1);
    chk("busy_after_arm", 32'(o_busy), 1);
    for (int k = 0; k < v.n; k++) begin
      if (bp && k == v.n - 1) force_busy = 1'b1;
      if (noise_arm && k == v.n - 1) i_arm = 1'b1;
      i_probe = v.probe[k];
      i_sample_en = 1'b1;
      @(negedge clk);
      i_sample_en = 1'b0;
      i_arm = 1'b0;
      chk("armed_after_strobe", 32'(o_armed), 32'(k < v.trig));
      chk("busy_during_capture", 32'(o_busy), 1);
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit noise_arm, input bit bp);
    int p0;
    p0 = pulses;
    capture_vec(v, noise_arm, bp);
    if (bp) begin
      repeat (20) @(negedge clk);
      chk("bp_no_strobe", 32'(pulses - p0), 0);
      chk("bp_busy_held", 32'(o_busy), 1);
      force_busy = 1'b0;
      @(negedge clk);
      chk("bp_strobe_after_release", 32'(o_tx_valid), 1);
    end
    if (noise_arm) begin
      wait_pulses(p0 + 3);
      i_arm = 1'b1;
      @(negedge clk);
      i_arm = 1'b0;
      chk("arm_ignored_streaming", 32'(o_armed), 0);
    end
    for (int c = 0; c < 3000 && o_busy; c++) @(negedge clk);
    chk("idle_timeout", 32'(o_busy), 0);
    chk("frame_len", 32'(pulses - p0), 7);
    chk("end_armed", 32'(o_armed), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{mask: 8'h0F, value: 8'h05, probe: {8'h34, 8'hF5, 8'h11, 8'h22, 8'h33, 8'h00},
                n: 5, trig: 1, exp_s: {8'hF5, 8'h11, 8'h22, 8'h33}, exp_csum: 8'hF5};
    vecs[1] = '{mask: 8'h00, value: 8'hFF, probe: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                n: 4, trig: 0, exp_s: {8'h00, 8'h00, 8'h00, 8'h00}, exp_csum: 8'h00};
    vecs[2] = '{mask: 8'hF0, value: 8'hA0, probe: {8'h0A, 8'hB1, 8'hA7, 8'h01, 8'h02, 8'h03},
                n: 6, trig: 2, exp_s: {8'hA7, 8'h01, 8'h02, 8'h03}, exp_csum: 8'hA7};
    vecs[3] = '{mask: 8'hFF, value: 8'h3C, probe: {8'h3D, 8'h3C, 8'hFF, 8'h80, 8'h55, 8'h00},
                n: 5, trig: 1, exp_s: {8'h3C, 8'hFF, 8'h80, 8'h55}, exp_csum: 8'h16};

    rst = 1'b1;
    i_probe = 8'h00; i_sample_en = 1'b0; i_arm = 1'b0;
    i_trig_mask = 8'h00; i_trig_value = 8'h00; force_busy = 1'b0;
    #12 zero_check("reset_outputs");
    @(negedge clk) rst = 1'b0;

    // Arm and strobe together in IDLE: the strobe must not be tested.
    i_trig_mask = 8'h00;
    i_arm = 1'b1;
    i_sample_en = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
    i_sample_en = 1'b0;
    chk("arm_with_strobe_armed", 32'(o_armed), 1);
    async_reset("reset_from_armed");

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0, 1'b0);
    run_vec(vecs[0], 1'b1, 1'b0);
    run_vec(vecs[2], 1'b0, 1'b1);

    // Reset in the middle of capture.
    @(negedge clk);
    i_trig_mask = 8'h00;
    i_arm = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
    repeat (2) begin
      i_sample_en = 1'b1;
      i_probe = 8'h5A;
      @(negedge clk);
      i_sample_en = 1'b0;
      @(negedge clk);
    end
    chk("mid_capture_armed", 32'(o_armed), 0);
    chk("mid_capture_busy", 32'(o_busy), 1);
    async_reset("reset_mid_capture");

    // Reset while waiting for the transmitter in TX_DONE.
    p0 = pulses;
    capture_vec(vecs[3], 1'b0, 1'b0);
    wait_pulses(p0 + 2);
    repeat (10) @(negedge clk);
    chk("mid_tx_model_active", 32'(mdl_active), 1);
    async_reset("reset_mid_tx_done");
    exp_q.delete();
    p0 = pulses;
    repeat (400) @(negedge clk);
    chk("no_bytes_after_reset", 32'(pulses - p0), 0);
    chk("idle_after_reset", 32'(o_busy), 0);

    run_vec(vecs[0], 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
